snax_banked_mem: RTL



---
 rtl/snax_banked_mem_pkg.sv | 26 ++
 rtl/snax_mem_bank.sv | 67 ++++++
 rtl/snax_banked_mem.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/snax_banked_mem_pkg.sv
// Shared types and derived-width helpers for the banked scratchpad.
package snax_banked_mem_pkg;

    // Round-robin token: which side wins the next narrow/wide conflict.
    typedef enum logic {
        NARROW = 1'b0,
        WIDE   = 1'b1
    } token_e;

    localparam token_e TokenReset = NARROW;

    // Word-index width of one bank; a single-word bank still gets one address bit.
    function automatic int unsigned calc_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One byte enable per byte of a bank word.
    function automatic int unsigned calc_strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/snax_mem_bank.sv
// One scratchpad bank: byte-strobed write, registered read and a fixed-latency
// response pipeline. The tag bit travels with each response so the top level
// can tell narrow responses from wide ones.
module snax_mem_bank
    import snax_banked_mem_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned BankDepth  = 1024,
    parameter int unsigned RspLatency = 1,
    localparam int unsigned AddrWidth = calc_addr_width(BankDepth),
    localparam int unsigned StrbWidth = calc_strb_width(DataWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic                 tag_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [StrbWidth-1:0] strb_i,
    output logic                 rsp_valid_o,
    output logic                 rsp_tag_o,
    output logic [DataWidth-1:0] rsp_data_o
);

    logic [DataWidth-1:0] mem_q [BankDepth];

    logic                 valid_q [RspLatency];
    logic                 tag_q   [RspLatency];
    logic [DataWidth-1:0] data_q  [RspLatency];

    // Storage array: only bytes with their strobe set are updated; never reset.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (strb_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register feeding the response shift pipeline; writes answer with zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < RspLatency; s++) begin
                valid_q[s] <= 1'b0;
                tag_q[s]   <= 1'b0;
                data_q[s]  <= '0;
            end
        end else begin
            valid_q[0] <= req_i;
            tag_q[0]   <= req_i & tag_i;
            data_q[0]  <= (req_i && !we_i) ? mem_q[addr_i] : '0;
            for (int s = 1; s < RspLatency; s++) begin
                valid_q[s] <= valid_q[s-1];
                tag_q[s]   <= tag_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign rsp_valid_o = valid_q[RspLatency-1];
    assign rsp_tag_o   = tag_q[RspLatency-1];
    assign rsp_data_o  = data_q[RspLatency-1];

endmodule

// File: rtl/snax_banked_mem.sv
// Banked scratchpad: per-bank narrow ports plus one all-bank wide port,
// round-robin conflict arbitration and a saturating conflict counter.
module snax_banked_mem
    import snax_banked_mem_pkg::*;
#(
    parameter int unsigned NumBanks   = 16,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned BankDepth  = 1024,
    parameter int unsigned RspLatency = 1,
    parameter int unsigned CntWidth   = 16,
    localparam int unsigned AddrWidth = calc_addr_width(BankDepth),
    localparam int unsigned StrbWidth = calc_strb_width(DataWidth)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumBanks-1:0]                  narrow_q_valid_i,
    output logic [NumBanks-1:0]                  narrow_q_ready_o,
    input  logic [NumBanks-1:0][AddrWidth-1:0]   narrow_q_addr_i,
    input  logic [NumBanks-1:0]                  narrow_q_write_i,
    input  logic [NumBanks-1:0][DataWidth-1:0]   narrow_q_wdata_i,
    input  logic [NumBanks-1:0][StrbWidth-1:0]   narrow_q_strb_i,
    output logic [NumBanks-1:0]                  narrow_p_valid_o,
    output logic [NumBanks-1:0][DataWidth-1:0]   narrow_p_data_o,
    input  logic                                 wide_q_valid_i,
    output logic                                 wide_q_ready_o,
    input  logic [AddrWidth-1:0]                 wide_q_addr_i,
    input  logic                                 wide_q_write_i,
    input  logic [NumBanks*DataWidth-1:0]        wide_q_wdata_i,
    input  logic [NumBanks*StrbWidth-1:0]        wide_q_strb_i,
    output logic                                 wide_p_valid_o,
    output logic [NumBanks*DataWidth-1:0]        wide_p_data_o,
    output logic [CntWidth-1:0]                  conflict_cnt_o
);

    // Reject configurations the bank model cannot represent.
    if (!is_pow2(BankDepth)) begin : g_chk_depth
        $error("snax_banked_mem: BankDepth must be a power of two");
    end
    if (RspLatency < 1) begin : g_chk_latency
        $error("snax_banked_mem: RspLatency must be at least 1");
    end
    if ((DataWidth % 8) != 0) begin : g_chk_width
        $error("snax_banked_mem: DataWidth must be a multiple of 8");
    end

    token_e               token_q, token_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    logic                 any_narrow;
    logic                 conflict;
    logic                 wide_grant;
    logic [NumBanks-1:0]  narrow_grant;

    logic [NumBanks-1:0]                bank_req;
    logic [NumBanks-1:0]                bank_we;
    logic [NumBanks-1:0][AddrWidth-1:0] bank_addr;
    logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
    logic [NumBanks-1:0][StrbWidth-1:0] bank_strb;
    logic [NumBanks-1:0]                bank_valid;
    logic [NumBanks-1:0]                bank_tag;
    logic [NumBanks-1:0][DataWidth-1:0] bank_rdata;

    // Grants: wide wins uncontested or when it holds the token; ready is
    // derived from valids and the token only, and forced low during reset.
    always_comb begin
        any_narrow   = |narrow_q_valid_i;
        conflict     = wide_q_valid_i && any_narrow;
        wide_grant   = !rst_i && wide_q_valid_i && (!any_narrow || (token_q == WIDE));
        narrow_grant = rst_i ? '0 : (narrow_q_valid_i & {NumBanks{!wide_grant}});
    end

    assign wide_q_ready_o   = wide_grant;
    assign narrow_q_ready_o = narrow_grant;

    // Next token goes to the side that lost this conflict; counter saturates.
    always_comb begin
        token_d = token_q;
        cnt_d   = cnt_q;
        if (conflict) begin
            token_d = wide_grant ? NARROW : WIDE;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            token_q <= TokenReset;
            cnt_q   <= '0;
        end else begin
            token_q <= token_d;
            cnt_q   <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;

    // Bank port mux: a wide grant steers every bank to its wide slice.
    always_comb begin
        for (int i = 0; i < NumBanks; i++) begin
            bank_req[i]   = wide_grant | narrow_grant[i];
            bank_we[i]    = wide_grant ? wide_q_write_i : narrow_q_write_i[i];
            bank_addr[i]  = wide_grant ? wide_q_addr_i : narrow_q_addr_i[i];
            bank_wdata[i] = wide_grant ? wide_q_wdata_i[i*DataWidth +: DataWidth]
                                       : narrow_q_wdata_i[i];
            bank_strb[i]  = wide_grant ? wide_q_strb_i[i*StrbWidth +: StrbWidth]
                                       : narrow_q_strb_i[i];
        end
    end

    for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
        snax_mem_bank #(
            .DataWidth  (DataWidth),
            .BankDepth  (BankDepth),
            .RspLatency (RspLatency)
        ) u_bank (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .req_i       (bank_req[gi]),
            .we_i        (bank_we[gi]),
            .tag_i       (wide_grant),
            .addr_i      (bank_addr[gi]),
            .wdata_i     (bank_wdata[gi]),
            .strb_i      (bank_strb[gi]),
            .rsp_valid_o (bank_valid[gi]),
            .rsp_tag_o   (bank_tag[gi]),
            .rsp_data_o  (bank_rdata[gi])
        );
    end

    // Response demux: the tag says whether a bank response belongs to the wide port.
    always_comb begin
        for (int i = 0; i < NumBanks; i++) begin
            narrow_p_valid_o[i]                   = bank_valid[i] & ~bank_tag[i];
            narrow_p_data_o[i]                    = bank_rdata[i];
            wide_p_data_o[i*DataWidth +: DataWidth] = bank_rdata[i];
        end
        wide_p_valid_o = bank_valid[0] & bank_tag[0];
    end

endmodule
